// File: rtl/fp_mul_arbiter_pkg.sv
// Shared definitions for the FP32 multiplier arbiter slice.
//   state_t     : arbiter FSM states (IDLE -> EXEC -> DONE)
//   FP_*        : FP32 field positions and exponent bias
package fp_mul_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned FP_SIGN     = 31;
  localparam int unsigned FP_EXP_MSB  = 30;
  localparam int unsigned FP_EXP_LSB  = 23;
  localparam int unsigned FP_MANT_MSB = 22;
  localparam int unsigned FP_BIAS     = 127;

endpackage

// File: rtl/fp.sv
// Combinational FP32 multiplier shared by the arbiter.
//   a, b : FP32 operands
//   p    : FP32 product (truncated; zero/denormal inputs give +0,
//          underflow flushes to +0, overflow saturates to infinity)
module fp
  import fp_mul_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);

  logic        sign;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic [47:0] prod;
  logic [9:0]  esum;
  logic [22:0] mant;

  always_comb begin
    sign = a[FP_SIGN] ^ b[FP_SIGN];
    ea   = a[FP_EXP_MSB:FP_EXP_LSB];
    eb   = b[FP_EXP_MSB:FP_EXP_LSB];
    ma   = {1'b1, a[FP_MANT_MSB:0]};
    mb   = {1'b1, b[FP_MANT_MSB:0]};
    prod = ma * mb;
    // Biased exponent sum still carrying one extra bias; normalisation adds 1
    // when the significand product lands in [2,4).
    esum = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]};
    mant = prod[47] ? prod[46:24] : prod[45:23];
    p    = '0;
    if (ea == '0 || eb == '0 || esum <= 10'(FP_BIAS)) begin
      p = '0;
    end else if (esum >= 10'(FP_BIAS + 255)) begin
      p = {sign, 8'hFF, 23'd0};
    end else begin
      p = {sign, 8'(esum - 10'(FP_BIAS)), mant};
    end
  end

endmodule

// File: rtl/fp_mul_arbiter_rr.sv
// Round-robin arbiter: searches upward from ptr (mod NREQ), first valid wins.
//   req   : request vector
//   ptr   : highest-priority index (always < NREQ)
//   grant : one-hot grant (zero when no request)
//   idx   : encoded index of the granted requester
//   any   : some request granted
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(ptr) + i) % NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one combinational FP32 multiplier among NREQ requesters.
// Round-robin grant in IDLE, operands registered, product registered with
// the requester tag and held until the consumer takes it.
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester request
//   req_a/b    : packed operands, requester i at [32*i+31:32*i]
//   req_ready  : one-hot grant (IDLE only)
//   rsp_valid  : result available; rsp_ready consumes it
//   rsp_p      : product, rsp_id : issuing requester
//   busy       : FSM not IDLE
//   op_count   : consumed operations, wraps
module fp_mul_arbiter
  import fp_mul_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1,
  parameter int unsigned CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_p,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy,
  output logic [CNTW-1:0]      op_count
);

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic [IDW-1:0]  win_id;
  logic [31:0]     win_a, win_b;
  logic [31:0]     op_a, op_b;
  logic [31:0]     fp_p;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  fp u_fp (
    .a (op_a),
    .b (op_b),
    .p (fp_p)
  );

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_a = req_a[32*i +: 32];
        win_b = req_b[32*i +: 32];
      end
    end
  end

  assign ptr_nxt = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (grant_any) state_nxt = EXEC;
      end
      EXEC: state_nxt = DONE;
      DONE: if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      win_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
      op_count  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_a   <= win_a;
            op_b   <= win_b;
            win_id <= grant_idx;
            ptr    <= ptr_nxt;
          end
        end
        EXEC: begin
          rsp_p     <= fp_p;
          rsp_id    <= win_id;
          rsp_valid <= 1'b1;
        end
        DONE: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
module tb_fp_mul_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 1;
  localparam int unsigned CNTW = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_p;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
  logic [CNTW-1:0]   op_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned exp_ptr  = 0;
  int unsigned exp_cnt  = 0;

  fp_mul_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference product through real arithmetic; operands are chosen so the
  // product is exactly representable, so no rounding question arises.
  function automatic real to_real(input logic [31:0] x);
    real m;
    int  e;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    m = m * (2.0 ** e);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    int          e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
    d = $realtobits(to_real(a) * to_real(b));
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    logic [10:0] m;
    logic [7:0]  e;
    r = $urandom;
    m = r[10:0];
    e = 8'($urandom_range(110, 144));
    return {r[31], e, m, 12'd0};
  endfunction

  task automatic run_op(input logic [1:0] vmask, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1, input int unsigned hold);
    int unsigned w;
    logic [31:0] ep;
    logic        found;
    found = 1'b0;
    w = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && vmask[(exp_ptr + k) % NREQ]) begin
        found = 1'b1;
        w = (exp_ptr + k) % NREQ;
      end
    end
    ep = (w == 0) ? fp_model(a0, b0) : fp_model(a1, b1);
    req_valid = vmask;
    req_a = {a1, a0};
    req_b = {b1, b0};
    #1;
    chk("grant", 64'(req_ready), 64'(2'b01 << w));
    chk("idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("exec_ready", 64'(req_ready), 64'd0);
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    chk("done_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("done_rsp_p", 64'(rsp_p), 64'(ep));
    chk("done_rsp_id", 64'(rsp_id), 64'(w));
    chk("done_ready", 64'(req_ready), 64'd0);
    for (int unsigned h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_p", 64'(rsp_p), 64'(ep));
      chk("hold_rsp_id", 64'(rsp_id), 64'(w));
      chk("hold_ready", 64'(req_ready), 64'd0);
      chk("hold_count", 64'(op_count), 64'(exp_cnt % 16));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 16;
    exp_ptr = (w + 1) % NREQ;
    chk("consume_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("consume_busy", 64'(busy), 64'd0);
    chk("consume_count", 64'(op_count), 64'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_p", 64'(rsp_p), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(op_count), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_req", 64'(req_ready), 64'd0);
    chk("idle_stays", 64'(busy), 64'd0);

    // single request, 1.0 * 1.0
    run_op(2'b01, 32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 0);
    chk("one_times_one", 64'(rsp_p), 64'h3F800000);
    // zero operand from requester 1
    run_op(2'b10, 32'h0, 32'h0, 32'h00000000, 32'h40400000, 0);
    chk("zero_operand", 64'(rsp_p), 64'h0);
    chk("zero_id", 64'(rsp_id), 64'd1);

    // both requesting continuously: grants must alternate
    for (int i = 0; i < 6; i++) begin
      run_op(2'b11, rand_fp(), rand_fp(), rand_fp(), rand_fp(), 0);
      chk("alternate_id", 64'(rsp_id), 64'(i % 2));
    end

    // consumer back-pressure
    run_op(2'b11, rand_fp(), rand_fp(), rand_fp(), rand_fp(), 5);

    // reset while an op is executing
    req_valid = 2'b01;
    req_a = {32'h0, 32'h40000000};
    req_b = {32'h0, 32'h40000000};
    #1;
    @(posedge clk); #1;
    req_valid = '0;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_count", 64'(op_count), 64'd0);
    chk("midrst_rsp_p", 64'(rsp_p), 64'd0);
    @(posedge clk); #1;
    chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    exp_ptr = 0;
    exp_cnt = 0;
    run_op(2'b11, rand_fp(), rand_fp(), rand_fp(), rand_fp(), 0);
    chk("post_rst_id", 64'(rsp_id), 64'd0);

    // drive the counter to its maximum and across the wrap
    for (int i = 0; i < 14; i++) begin
      run_op(2'($urandom_range(1, 3)), rand_fp(), rand_fp(), rand_fp(), rand_fp(), 0);
    end
    chk("count_max", 64'(op_count), 64'd15);
    run_op(2'($urandom_range(1, 3)), rand_fp(), rand_fp(), rand_fp(), rand_fp(), 0);
    chk("count_wrap", 64'(op_count), 64'd0);

    req_valid = '0;
    @(posedge clk); #1;
    chk("final_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
